pulse_period_meter: RTL and testbench
=====================================

PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 SHALL have parameter N, default 4, meaning the width of the period counter and the period output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port ena, input, 1 bit: measurement enable.
REQ-005 SHALL have port in, input, 1 bit: pulse stream, synchronous to clk (for example, a pulse_generator output).
REQ-006 SHALL have port period, output, N bits: last measured rising-edge-to-rising-edge interval, in clk cycles.
REQ-007 SHALL have port valid, output, 1 bit: one-cycle strobe marking a new period value.
REQ-008 SHALL have port timeout, output, 1 bit: sticky flag meaning no edge arrived within 2^N-1 cycles.

Function
REQ-009 SHALL register in into in_q every cycle, regardless of ena or state.
REQ-010 SHALL define a rising edge as in=1 and in_q=0 in the same cycle.
REQ-011 SHALL implement the states IDLE, ARMED and MEASURING.
REQ-012 SHALL, in IDLE, hold the counter at 0 and ignore edges, and go to ARMED on the next cycle when ena=1.
REQ-013 SHALL, in ARMED, load the counter with 1 and go to MEASURING on a rising edge, and produce no valid strobe.
REQ-014 SHALL, in MEASURING with no edge, increment the counter by 1 each cycle.
REQ-015 SHALL, in MEASURING on a rising edge, load period with the current counter value, set valid=1 for exactly the next cycle, set the counter to 1, and clear timeout, all in the same clock.
REQ-016 SHALL, as a result of REQ-013 to REQ-015, report period = K for edges exactly K cycles apart (edges 6 cycles apart give period=6).
REQ-017 SHALL, in MEASURING when the counter equals 2^N-1 and there is no edge, set timeout=1, leave period unchanged, and go to ARMED.
REQ-018 SHALL give the edge priority over the timeout when both occur in the same cycle: the measurement uses period=2^N-1 and timeout stays 0.
REQ-019 SHALL never let the counter wrap around.
REQ-020 SHALL, when ena=0 in any state, go to IDLE next cycle, zero the counter, force valid=0 and clear timeout, while period keeps its last value.
REQ-021 SHALL not detect an edge when ena rises while in is already high, because in_q tracks in continuously (REQ-009).
REQ-022 SHALL drive outputs directly from registers, with no combinational path from input to output.

Reset
REQ-023 SHALL, when rst=1, set the state to IDLE and set the counter, in_q, period, valid and timeout all to 0 on the next clk edge.
REQ-024 SHALL let rst override ena and any in-progress measurement, with no valid strobe in the cycle after reset.
REQ-025 SHALL, after rst is released with ena=1, enter ARMED one cycle later; the first valid output needs two rising edges.

Structure
REQ-026 SHALL take the state enum typedef (IDLE, ARMED, MEASURING) from shared package pulse_pkg, which pulse_generator-family blocks also import.
REQ-027 SHALL instantiate one sub-module, edge_detector (clk, rst, in -> rising), which holds the in_q register.
REQ-028 SHALL use a saturation compare against an all-ones constant, derived from N rather than hard-coded.

Verification
REQ-029 SHALL cover: N=4, in pulsed high for 1 cycle every 6 cycles, ena=1 -> first valid after the 2nd edge with period=6, then valid every 6 cycles, timeout=0.
REQ-030 SHALL cover: pulse spacing changed from 6 to 3 mid-stream -> the next strobe reports period=6, each later one period=3, with no missed or extra strobes.
REQ-031 SHALL cover: in held low for 20 cycles after a measurement (N=4) -> timeout=1 exactly 15 cycles after the last edge, period unchanged; the next edge gives no valid, and the one after clears timeout and reports the spacing.
REQ-032 SHALL cover: edges exactly 15 cycles apart (N=4) -> valid with period=15, timeout stays 0.
REQ-033 SHALL cover: ena dropped for 4 cycles mid-measurement while in is high at re-enable -> valid=0 throughout, timeout=0, and no edge seen until the next genuine 0->1 transition.
REQ-034 SHALL cover: rst asserted for 1 cycle in MEASURING -> all outputs 0 next cycle, and a full re-arm with 2 edges is needed before the next valid.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse_generator / pulse measurement family.
package pulse_pkg;

    // Measurement FSM states shared by the pulse-family blocks.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        MEASURING = 2'd2
    } state_t;

endpackage : pulse_pkg

// File: rtl/pulse_period_meter_edge_detector.sv
// Rising-edge detector: keeps a one-cycle delayed copy of the pulse stream.
module edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rising
);

    logic in_q;

    // Delay the input every cycle so an edge is never seen on a level already high.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign rising = in & ~in_q;

endmodule : edge_detector

// File: rtl/pulse_period_meter.sv
// Measures rising-edge-to-rising-edge spacing of a pulse stream in clk cycles,
// with a one-cycle valid strobe and a sticky timeout when no edge arrives in time.
module pulse_period_meter
    import pulse_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         in,
    output logic [N-1:0] period,
    output logic         valid,
    output logic         timeout
);

    // Largest count the counter may hold; reaching it without an edge is a timeout.
    localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q;
    logic [N-1:0] cnt_q;
    logic [N-1:0] period_q;
    logic         valid_q;
    logic         timeout_q;
    logic         rising;

    edge_detector u_edge (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .rising (rising)
    );

    // Measurement FSM; counter, period, strobe and timeout all update here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else if (!ena) begin
            // Disabling abandons any measurement but keeps the last period.
            state_q   <= IDLE;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q   <= '0;
                    state_q <= ARMED;
                end
                ARMED: begin
                    // First edge only starts the count; no period exists yet.
                    if (rising) begin
                        cnt_q   <= CNT_ONE;
                        state_q <= MEASURING;
                    end
                end
                MEASURING: begin
                    // An edge wins over saturation in the same cycle.
                    if (rising) begin
                        period_q  <= cnt_q;
                        valid_q   <= 1'b1;
                        cnt_q     <= CNT_ONE;
                        timeout_q <= 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= ARMED;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule : pulse_period_meter

// File: tb/tb_pulse_period_meter.sv
// Directed table-driven bench for pulse_period_meter with N=4.
module tb_pulse_period_meter;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       in;
    logic [3:0] period;
    logic       valid;
    logic       timeout;

    int total;
    int bad;
    int cyc;

    typedef struct {
        logic       rst;
        logic       ena;
        logic       in;
        logic       exp_valid;
        logic [3:0] exp_period;
        logic       exp_timeout;
    } vec_t;

    vec_t vq[$];

    pulse_period_meter #(.N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .in      (in),
        .period  (period),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, then check the registered outputs after the edge.
    task automatic step(input logic r, input logic e, input logic i,
                        input logic ev, input logic [3:0] ep, input logic et,
                        input string tag);
        rst = r;
        ena = e;
        in  = i;
        @(posedge clk);
        #1;
        total++;
        if (valid !== ev) begin
            bad++;
            $display("FAIL %s valid cyc=%0d got=%b want=%b", tag, cyc, valid, ev);
        end
        total++;
        if (period !== ep) begin
            bad++;
            $display("FAIL %s period cyc=%0d got=%0d want=%0d", tag, cyc, period, ep);
        end
        total++;
        if (timeout !== et) begin
            bad++;
            $display("FAIL %s timeout cyc=%0d got=%b want=%b", tag, cyc, timeout, et);
        end
        cyc++;
    endtask

    initial begin
        int edges[$];
        int strobe_cyc[$];
        int strobe_per[$];
        logic [3:0] held;
        vec_t v;

        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b1;
        ena   = 1'b0;
        in    = 1'b0;

        // Single-cycle pulses: 6 apart, then 3 apart, a 20-cycle gap (timeout),
        // re-arm, 15 apart, ena drop with in high, then a reset mid-measurement.
        edges      = '{2, 8, 14, 20, 23, 26, 29, 50, 55, 70, 80, 84, 89, 93};
        strobe_cyc = '{8, 14, 20, 23, 26, 29, 55, 70, 84, 93};
        strobe_per = '{6, 6, 6, 3, 3, 3, 5, 15, 4, 4};

        held = 4'd0;
        for (int j = 0; j <= 95; j++) begin
            v.rst = (j == 0 || j == 87);
            v.ena = !(j >= 73 && j <= 76);
            v.in  = (j >= 75 && j <= 78);
            foreach (edges[k]) if (edges[k] == j) v.in = 1'b1;
            v.exp_valid = 1'b0;
            if (v.rst) held = 4'd0;
            foreach (strobe_cyc[k]) begin
                if (strobe_cyc[k] == j) begin
                    v.exp_valid = 1'b1;
                    held = 4'(strobe_per[k]);
                end
            end
            v.exp_period  = held;
            v.exp_timeout = (j >= 44 && j <= 54);
            vq.push_back(v);
        end

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].ena, vq[i].in,
                 vq[i].exp_valid, vq[i].exp_period, vq[i].exp_timeout, "table");
        end

        // Edge arriving in the same cycle ena drops: no strobe, period kept.
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "seq_rst");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "seq_arm");
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, "seq_edge1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "seq_cnt");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "seq_cnt");
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "seq_edge_ena0");
        // Re-enable with in high: armed but the level is not an edge.
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, "seq_reen");
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, "seq_high");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "seq_low");
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, "seq_first_edge");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "seq_cnt");
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, "seq_period2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, "seq_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pulse_period_meter
